// File: rtl/rv_pkg.sv
// Shared fetch-side constants: reset vector, instruction size, canonical NOP.
// No logic, no latency, no flow control.
package rv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush. A write is visible at the head one cycle later.
// No internal backpressure: the caller must never push when full without popping, nor pop when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC register feeding a combinational instruction memory, results queued for decode.
// Redirect flushes and retargets in one cycle; when the queue is full and decode stalls, the PC freezes.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(RESET_PC_DEFAULT),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] instr,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              fq_valid,
  output logic [DWIDTH-1:0] fq_instr,
  output logic [AWIDTH-1:0] fq_pc,
  input  logic              fq_ready,
  output logic [31:0]       fetch_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     push;
  logic                     pop;
  logic [CW-1:0]            count;
  logic [AWIDTH+DWIDTH-1:0] head;

  // A head that coincides with a redirect is wrong-path, so the handshake is squashed.
  assign fq_valid = (count != '0) && !redirect_valid;
  assign pop      = fq_valid && fq_ready;
  assign push     = !redirect_valid && ((count < CW'(DEPTH)) || pop);

  assign {fq_pc, fq_instr} = head;

  fetch_fifo #(
    .WIDTH (AWIDTH + DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc, instr}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[AWIDTH-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + AWIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (push && (fetch_count != '1)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed + random bench for ifetch_unit with a queue scoreboard of expected (pc, instr) deliveries.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_ready;
  logic [31:0] fetch_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  ent_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic        exp_valid;

  ifetch_unit #(
    .AWIDTH   (32),
    .DWIDTH   (32),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq_valid       (fq_valid),
    .fq_instr       (fq_instr),
    .fq_pc          (fq_pc),
    .fq_ready       (fq_ready),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'd12:  r = 32'h4044_04b3;
      32'd16:  r = 32'h0041_4433;
      default: r = (a[5:2] == 4'hF) ? NOP_INSTR : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endcase
    return r;
  endfunction

  assign instr = mem_word(pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = RST_PC;
    m_fc = '0;
  endtask

  // Check this cycle's outputs, then advance the reference model across the coming edge.
  task automatic cycle();
    ent_t popped;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0) && !redirect_valid;
    check("pc", pc, m_pc);
    check("fq_valid", {31'b0, fq_valid}, {31'b0, exp_valid});
    check("fetch_count", fetch_count, m_fc);
    if (exp_valid) begin
      check("fq_pc", fq_pc, exp_q[0].pc);
      check("fq_instr", fq_instr, exp_q[0].instr);
      if (exp_q[0].pc == 32'd12) check("instr_at_12", fq_instr, 32'h4044_04b3);
    end else if (exp_q.size() == 0) begin
      check("fq_pc_empty", fq_pc, 32'h0);
      check("fq_instr_empty", fq_instr, 32'h0);
    end
    if (exp_valid && fq_ready) popped = exp_q.pop_front();
    if (redirect_valid) begin
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
      if (m_fc != '1) m_fc = m_fc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called at posedge+1: brief reset pulse released before the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b1;
    fq_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_pc", pc, RST_PC);
    check("rst_fq_valid", {31'b0, fq_valid}, 32'h0);
    check("rst_fq_pc", fq_pc, 32'h0);
    check("rst_fq_instr", fq_instr, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Streaming from reset with decode always ready.
    cycles(8);

    // Decode stalls: queue fills to DEPTH and the PC freezes.
    do_reset();
    fq_ready = 1'b0;
    cycles(5);
    check("stall_pc", pc, 32'h8);
    check("stall_fetch_count", fetch_count, 32'd2);
    fq_ready = 1'b1;
    cycles(5);

    // Redirect with a full queue and decode ready: both entries squashed.
    fq_ready = 1'b0;
    cycles(3);
    fq_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0028;
    cycle();
    redirect_valid = 1'b0;
    check("redir_pc", pc, 32'h28);
    cycles(4);

    // Misaligned target is force-aligned.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_002A;
    cycle();
    redirect_valid = 1'b0;
    check("align_pc", pc, 32'h28);
    cycles(3);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    cycles(4);

    // Asynchronous reset mid-cycle with a full queue.
    fq_ready = 1'b0;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_fq_valid", {31'b0, fq_valid}, 32'h0);
    check("arst_fq_pc", fq_pc, 32'h0);
    check("arst_fq_instr", fq_instr, 32'h0);
    check("arst_fetch_count", fetch_count, 32'h0);
    check("arst_pc", pc, RST_PC);
    model_reset();
    rst_n    = 1'b1;
    fq_ready = 1'b1;
    cycles(4);

    // Random decode stalls and redirects.
    for (int i = 0; i < 10000; i++) begin
      fq_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      cycle();
    end
    redirect_valid = 1'b0;
    fq_ready       = 1'b1;
    cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
